// File: rtl/nn_bias_pkg.sv
// Shared types and default geometry for the MLP output-layer bias store.
// Used by bias_stream_loader and the layer-3 datapath.
package nn_bias_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_DEPTH  = 10;
   localparam int unsigned DEF_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } bias_state_e;

   // States in which the loader accepts stream words.
   function automatic logic state_accepts(input bias_state_e s);
      return (s == LOAD) || (s == CHECK);
   endfunction

endpackage

// File: rtl/bias_stream_loader_if.sv
// Stream, read-port and status bundle between the host/datapath and bias_stream_loader.
import nn_bias_pkg::*;

interface bias_stream_loader_if #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

   logic              start;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic [ADDR_W-1:0] ra1;
   logic [DATA_W-1:0] rd1;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] wr_count;

   modport master (
      output start, s_valid, s_data, ra1,
      input  s_ready, rd1, busy, done, err, wr_count
   );

   modport slave (
      input  start, s_valid, s_data, ra1,
      output s_ready, rd1, busy, done, err, wr_count
   );

endinterface

// File: rtl/bias_rf_ram.sv
// DEPTH x DATA_W bias register file: one synchronous write port, one
// combinational read port, whole array cleared by asynchronous reset.
import nn_bias_pkg::*;

module bias_rf_ram #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   output logic [DATA_W-1:0] rd1
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wa_ok;
   logic              w_ra_ok;

   assign w_wa_ok = (wa  < ADDR_W'(DEPTH));
   assign w_ra_ok = (ra1 < ADDR_W'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (we && w_wa_ok) begin
         r_mem[IDX_W'(wa)] <= wd;
      end
   end

   // Out-of-range addresses read as zero.
   assign rd1 = w_ra_ok ? r_mem[IDX_W'(ra1)] : '0;

endmodule

// File: rtl/bias_stream_loader.sv
// Run-time bias loader: fills bias_rf_ram sequentially from a valid/ready stream.
// Optional trailing checksum word is enabled by BIAS_LOAD_CHECKSUM_EN.
import nn_bias_pkg::*;

module bias_stream_loader #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input logic                clk,
   input logic                reset,
   bias_stream_loader_if.slave bus
);

   bias_state_e       r_state;
   bias_state_e       w_state_nxt;
   logic [ADDR_W-1:0] r_wr_count;
   logic              r_s_ready;
   logic              r_busy;
   logic              r_done;
   logic              w_hs;
   logic              w_last;
   logic              w_restart;
   logic              w_we;
   logic [DATA_W-1:0] w_rd1;

   assign w_hs   = bus.s_valid & r_s_ready;
   assign w_last = (r_wr_count == ADDR_W'(DEPTH - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_state_nxt = LOAD;
               w_restart   = 1'b1;
            end
         end
         LOAD: begin
            w_we = w_hs;
            if (w_hs && w_last) begin
`ifdef BIAS_LOAD_CHECKSUM_EN
               w_state_nxt = CHECK;
`else
               w_state_nxt = DONE;
`endif
            end
         end
`ifdef BIAS_LOAD_CHECKSUM_EN
         CHECK: begin
            if (w_hs) begin
               w_state_nxt = DONE;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they never depend on s_valid combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_s_ready  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wr_count <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_s_ready <= state_accepts(w_state_nxt);
         r_busy    <= state_accepts(w_state_nxt);
         r_done    <= (w_state_nxt == DONE);
         if (w_restart) begin
            r_wr_count <= '0;
         end else if (w_we) begin
            r_wr_count <= r_wr_count + ADDR_W'(1);
         end
      end
   end

`ifdef BIAS_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] r_sum;
   logic              r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if (w_restart) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if (w_we) begin
         r_sum <= r_sum + bus.s_data;
      end else if ((r_state == CHECK) && w_hs) begin
         r_err <= (bus.s_data != r_sum);
      end
   end

   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif

   bias_rf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (w_we),
      .wa    (r_wr_count),
      .wd    (bus.s_data),
      .ra1   (bus.ra1),
      .rd1   (w_rd1)
   );

   assign bus.s_ready  = r_s_ready;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.wr_count = r_wr_count;
   assign bus.rd1      = w_rd1;

endmodule

// File: tb/tb_bias_stream_loader.sv
// Self-checking bench for bias_stream_loader against a transaction-level model;
// checksum scenarios are included when BIAS_LOAD_CHECKSUM_EN is defined.
module tb_bias_stream_loader;
   import nn_bias_pkg::*;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 10;
   localparam int unsigned ADDR_W = 6;
`ifdef BIAS_LOAD_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;

   bias_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   bias_stream_loader #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: contents, words accepted in this load, words still expected, flags.
   logic [15:0] m_rf [DEPTH];
   int          m_cnt;
   int          m_left;
   bit          m_active;
   bit          m_done;
   bit          m_err;
   logic [15:0] m_sum;
   logic [15:0] words [DEPTH+1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int a);
      return (a < int'(DEPTH)) ? 32'(m_rf[a]) : 32'd0;
   endfunction

   function automatic int rand_ra();
      return int'($urandom_range(0, 20));
   endfunction

   task automatic model_edge(input bit st, input bit v, input logic [15:0] d);
      if (!m_active) begin
         if (st) begin
            m_active = 1'b1;
            m_left   = int'(DEPTH) + CK;
            m_cnt    = 0;
            m_sum    = 16'h0;
            m_done   = 1'b0;
            m_err    = 1'b0;
         end
      end else if (v) begin
         if (m_cnt < int'(DEPTH)) begin
            m_rf[m_cnt] = d;
            m_cnt++;
            m_sum = m_sum + d;
         end else begin
            m_err = (d != m_sum);
         end
         m_left--;
         if (m_left == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
   endtask

   task automatic chk_outputs();
      chk("s_ready",  32'(bus.s_ready),  32'(m_active));
      chk("busy",     32'(bus.busy),     32'(m_active));
      chk("done",     32'(bus.done),     32'(m_done));
      chk("err",      32'(bus.err),      32'(m_err));
      chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
   endtask

   // One clock: drive at edge+1, check read before edge, advance model, check after edge.
   task automatic cycle(input bit st, input bit v, input logic [15:0] d, input int ra);
      bus.start   = st;
      bus.s_valid = v;
      bus.s_data  = d;
      bus.ra1     = ADDR_W'(ra);
      #1;
      chk("rd1_pre", 32'(bus.rd1), exp_rd(ra));
      @(posedge clk);
      model_edge(st, v, d);
      #1;
      chk_outputs();
      chk("rd1_post", 32'(bus.rd1), exp_rd(ra));
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_cnt    = 0;
      m_left   = 0;
      m_sum    = 16'h0;
      for (int i = 0; i < int'(DEPTH); i++) m_rf[i] = 16'h0;
      #1;
      chk_outputs();
      for (int a = 0; a < 4; a++) begin
         bus.ra1 = ADDR_W'(a);
         #1;
         chk("rst_rd1", 32'(bus.rd1), 32'd0);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // mode 0: valid held high, 1: valid every other cycle, 2: random valid and stray starts.
   task automatic run_load(input int mode, input int exp_lat, input string tag);
      int lat;
      bit v;
      bit st;
      lat = 0;
      cycle(1'b1, 1'b0, 16'h0, rand_ra());
      while (bus.done !== 1'b1 && lat < 80) begin
         v  = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(lat % 2) : bit'($urandom_range(0, 1));
         st = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
         cycle(st, v, words[m_cnt], rand_ra());
         lat++;
      end
      if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic fill_checksum(input bit corrupt);
      logic [15:0] s;
      s = 16'h0;
      for (int i = 0; i < int'(DEPTH); i++) s = s + words[i];
      words[DEPTH] = corrupt ? s + 16'h1 : s;
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.ra1     = '0;
      #3;
      apply_reset();

      // Back-to-back load of 1..10.
      for (int i = 0; i < int'(DEPTH); i++) words[i] = 16'(i + 1);
      fill_checksum(1'b0);
      run_load(0, int'(DEPTH) + CK, "b2b");
      chk("b2b_wr_count", 32'(bus.wr_count), 32'(DEPTH));
      for (int a = 0; a < int'(DEPTH); a++) begin
         cycle(1'b0, 1'b0, 16'h0, a);
         chk("b2b_rd", 32'(bus.rd1), 32'(a + 1));
      end
      cycle(1'b0, 1'b0, 16'h0, 12);
      chk("b2b_rd_oob", 32'(bus.rd1), 32'd0);

      // Same load, valid toggling.
      run_load(1, 2 * (int'(DEPTH) + CK), "toggle");
      for (int a = 0; a < int'(DEPTH); a++) begin
         cycle(1'b0, 1'b1, 16'hFFFF, a);
         chk("toggle_rd", 32'(bus.rd1), 32'(a + 1));
      end

      // Write to address 3 while reading it: old value, then new value.
      cycle(1'b1, 1'b0, 16'h0, 0);
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (i == 3) begin
            cycle(1'b0, 1'b1, 16'h1234, 3);
            chk("rw_new", 32'(bus.rd1), 32'h1234);
         end else begin
            cycle(1'b0, 1'b1, 16'($urandom), rand_ra());
         end
      end
      for (int i = 0; i < CK; i++) cycle(1'b0, 1'b1, m_sum, rand_ra());
      chk("rw_done", 32'(bus.done), 32'd1);

      // start during LOAD is ignored; start in DONE reloads.
      for (int i = 0; i < int'(DEPTH); i++) words[i] = 16'($urandom);
      fill_checksum(1'b0);
      cycle(1'b1, 1'b0, 16'h0, rand_ra());
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, words[m_cnt], rand_ra());
      cycle(1'b1, 1'b1, words[m_cnt], rand_ra());
      chk("start_in_load_count", 32'(bus.wr_count), 32'd6);
      for (int k = 0; k < 40 && bus.done !== 1'b1; k++) cycle(1'b0, 1'b1, words[m_cnt], rand_ra());
      chk("start_in_load_done", 32'(bus.done), 32'd1);
      cycle(1'b1, 1'b0, 16'h0, rand_ra());
      chk("restart_done_drop", 32'(bus.done), 32'd0);
      chk("restart_count_clr", 32'(bus.wr_count), 32'd0);
      for (int i = 0; i < int'(DEPTH); i++) words[i] = 16'($urandom);
      fill_checksum(1'b0);
      for (int k = 0; k < 40 && bus.done !== 1'b1; k++) cycle(1'b0, 1'b1, words[m_cnt], rand_ra());
      for (int a = 0; a < int'(DEPTH); a++) cycle(1'b0, 1'b0, 16'h0, a);

`ifdef BIAS_LOAD_CHECKSUM_EN
      // Checksum wraps modulo 2**16.
      for (int i = 0; i < int'(DEPTH); i++) words[i] = 16'h0;
      words[0] = 16'h8000;
      words[1] = 16'h8000;
      words[DEPTH] = 16'h0000;
      run_load(0, int'(DEPTH) + 1, "ck_ok");
      chk("ck_ok_err", 32'(bus.err), 32'd0);
      words[DEPTH] = 16'h0001;
      run_load(0, int'(DEPTH) + 1, "ck_bad");
      chk("ck_bad_err", 32'(bus.err), 32'd1);
      cycle(1'b0, 1'b0, 16'h0, 1);
      chk("ck_bad_stored", 32'(bus.rd1), 32'h8000);
`endif

      // Reset after four handshakes discards the partial load.
      cycle(1'b1, 1'b0, 16'h0, rand_ra());
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'($urandom) | 16'h1, i);
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'($urandom), i);
      chk("post_rst_count", 32'(bus.wr_count), 32'd0);
      chk("post_rst_ready", 32'(bus.s_ready), 32'd0);
      cycle(1'b0, 1'b0, 16'h0, 0);
      chk("post_rst_rd0", 32'(bus.rd1), 32'd0);

      // Random loads with gaps, stray starts and idle-time valid.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < int'(DEPTH); i++) words[i] = 16'($urandom);
         fill_checksum(bit'($urandom_range(0, 1)));
         run_load(2, -1, "rand");
         chk("rand_done", 32'(bus.done), 32'd1);
         for (int k = 0; k < 3; k++) cycle(1'b0, bit'($urandom_range(0, 1)), 16'($urandom), rand_ra());
         for (int a = 0; a < int'(DEPTH) + 2; a++) cycle(1'b0, bit'($urandom_range(0, 1)), 16'($urandom), a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
